ship_motion_ctrl: RTL
=====================

// Module: ship_motion_ctrl
// PURPOSE
//  Converts latched accelerometer X/Y samples into the spaceship sprite's screen position.
//  Sits between the accelerometer sample latch and the spaceship sprite's sprite_x/sprite_y inputs.
//  Each axis has a 4-sample moving-average filter, a dead-zone and a speed ladder.
//  Position is clamped so the scaled sprite never leaves the 640x480 screen.
// PARAMETERS
//  H_RES      640  visible width (pixels)
//  V_RES      480  visible height (pixels)
//  SPRITE_W   34   on-screen sprite width (17 x SCALE 2)
//  SPRITE_H   36   on-screen sprite height (18 x SCALE 2)
//  CORDW      16   coordinate width (bits)
//  X_INIT     50   reset x position
//  Y_INIT     240  reset y position
//  DEADZONE   64   |avg| below this gives zero motion (LSB counts)
//  STEP_MAX   4    largest per-cycle step (pixels)
// PORTS
//  slowclk       in   1      clock (slow tick domain)
//  reset_n       in   1      synchronous, active-low reset
//  sample_valid  in   1      accel_x/accel_y are a new sample this cycle
//  accel_x       in   16     signed two's-complement tilt, X axis
//  accel_y       in   16     signed two's-complement tilt, Y axis
//  freeze        in   1      hold position; filters keep running
//  pos_x         out  CORDW  sprite x (top-left)
//  pos_y         out  CORDW  sprite y (top-left)
//  moving        out  1      1 while any nonzero step is being applied
//  at_edge       out  4      {top,bottom,left,right}; bit set when pos is at the clamp limit
// BEHAVIOUR
//  Reset (reset_n=0 at a slowclk edge):
//   - pos=(X_INIT,Y_INIT), moving=0, at_edge=0000.
//   - Windows, sums and registered averages are cleared.
//   - FSM goes to FILL.
//   - Reset applies identically mid-operation.
//  Filter pipeline (per axis):
//   - On an edge with sample_valid=1, the sample is shifted into a 4-deep window and an 18-bit signed running sum is updated.
//   - One edge later: avg = sum >>> 2 (arithmetic shift), registered.
//  FSM:
//   - FILL: counts accepted samples. On the 4th accepted sample it moves to RUN.
//   - RUN: position updates every edge from the registered avg. Stays in RUN until reset.
//   - First possible motion is 2 edges after the 4th sample is accepted.
//  Step per axis, from mag = |avg|:
//   - Saturate: -32768 gives 32767.
//   - mag < DEADZONE: step 0
//   - mag < 2*DEADZONE: step 1
//   - mag < 4*DEADZONE: step 2
//   - otherwise: STEP_MAX
//   - Direction: avg > 0 increments pos, avg < 0 decrements.
//  Clamp:
//   - x in [0, H_RES-SPRITE_W], y in [0, V_RES-SPRITE_H].
//   - Saturate; never wrap.
//   - A decrement larger than the current pos lands on 0.
//   - Compute in CORDW+1 bits so there is no underflow.
//  Flags:
//   - at_edge is registered together with pos and reflects the new pos.
//   - moving=1 iff some axis step != 0 and freeze=0 this edge, even if the clamp absorbs the step.
//  freeze=1: pos holds, moving=0, filters keep updating. Release resumes motion on the next edge.
//  sample_valid=0: window and avg hold; motion continues at the last avg.
// STRUCTURE
//  Package ship_pkg holds:
//   - coord_t (logic [CORDW-1:0])
//   - enum {FILL,RUN} motion_state_t
//   - function step_from_mag(mag, DEADZONE, STEP_MAX)
//  Sub-module axis_filter: window, running sum, registered avg. One instance per axis.
//  Top level: FSM, step logic and clamp, both axes in parallel.
// TESTING
//  - Reset: reset_n=0 for 3 edges -> pos=(50,240), moving=0, at_edge=0, FSM=FILL.
//  - Fill: 4 samples x=+200, y=0 -> no motion before RUN; avg_x=200 -> step 2; pos_x 50,52,54...; pos_y stays 240.
//  - Dead-zone: x=-30 (steady, window full) -> pos unchanged, moving=0.
//  - Clamp: pos_x=604, x=+1000 -> pos_x 606 next edge, then holds at 606; at_edge[0]=1, moving=1.
//  - Negative clamp: pos_y=2, y=-1000 -> pos_y 0; at_edge[3]=1; no wrap to 65534.
//  - Freeze/reset: freeze=1 under x=+1000 -> pos constant, moving=0; release -> +4 next edge; reset_n=0 mid-RUN -> (50,240), FILL.

Source files
------------

// File: rtl/ship_pkg.sv
// Shared types, screen geometry and per-axis motion helpers for the
// spaceship motion controller.
package ship_pkg;

  localparam int CORDW    = 16;
  localparam int ACCW     = 16;  // accelerometer sample width
  localparam int SUMW     = 18;  // running sum of four samples
  localparam int STEPW    = 3;   // width of a per-cycle step
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int SPRITE_W = 34;
  localparam int SPRITE_H = 36;
  localparam int X_INIT   = 50;
  localparam int Y_INIT   = 240;
  localparam int DEADZONE = 64;
  localparam int STEP_MAX = 4;

  typedef logic [CORDW-1:0] coord_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } motion_state_t;

  // |v| with the single unrepresentable case (-32768) saturated to 32767.
  function automatic logic [ACCW-1:0] sat_abs(input logic signed [ACCW-1:0] v);
    if (v == 16'sh8000)
      return 16'h7fff;
    else if (v < 0)
      return 16'(-v);
    else
      return v;
  endfunction

  // Speed ladder: dead-zone, 1, 2, then the maximum step.
  function automatic logic [STEPW-1:0] step_from_mag(
    input logic [ACCW-1:0]  mag,
    input logic [ACCW-1:0]  deadzone,
    input logic [STEPW-1:0] step_max
  );
    logic [ACCW+1:0] m;
    logic [ACCW+1:0] dz;
    m  = {2'b00, mag};
    dz = {2'b00, deadzone};
    if (m < dz)
      return 3'd0;
    else if (m < (dz << 1))
      return 3'd1;
    else if (m < (dz << 2))
      return 3'd2;
    else
      return step_max;
  endfunction

  // Move pos by step in the direction of avg, saturating into [0, lim].
  // One extra bit of headroom keeps the add and subtract from wrapping.
  function automatic coord_t clamp_move(
    input coord_t                  pos,
    input logic signed [ACCW-1:0]  avg,
    input logic [STEPW-1:0]        step,
    input coord_t                  lim
  );
    localparam int CW1 = CORDW + 1;
    logic [CORDW:0] wide;
    wide = {1'b0, pos};
    if (avg > 0) begin
      wide = {1'b0, pos} + CW1'(step);
      if (wide > {1'b0, lim})
        wide = {1'b0, lim};
    end else if (avg < 0) begin
      if ({1'b0, pos} < CW1'(step))
        wide = '0;
      else
        wide = {1'b0, pos} - CW1'(step);
    end
    return wide[CORDW-1:0];
  endfunction

endpackage

// File: rtl/axis_filter.sv
// One axis of the tilt filter: 4-deep sample window, running sum, and a
// registered average (sum / 4, arithmetic) that lags the sum by one edge.
module axis_filter
  import ship_pkg::*;
(
  input  logic                   slowclk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  input  logic signed [ACCW-1:0] i_sample,
  output logic signed [ACCW-1:0] o_avg
);

  logic signed [ACCW-1:0] r_win [4];
  logic signed [SUMW-1:0] r_sum;
  logic signed [ACCW-1:0] r_avg;

  // Shift new samples in, keep the sum current, and register the average.
  always_ff @(posedge slowclk) begin
    if (!reset_n) begin
      // NOTE: the window is a flop array, not a RAM, so it is cleared on
      // reset; otherwise stale samples would leak into the first averages.
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_sum <= '0;
      r_avg <= '0;
    end else begin
      if (i_valid) begin
        // NOTE: non-blocking assignments let every stage read its pre-edge
        // neighbour, so the window shifts instead of collapsing.
        r_win[0] <= i_sample;
        r_win[1] <= r_win[0];
        r_win[2] <= r_win[1];
        r_win[3] <= r_win[2];
        r_sum    <= r_sum + SUMW'(i_sample) - SUMW'(r_win[3]);
      end
      r_avg <= ACCW'(r_sum >>> 2);
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/ship_motion_ctrl.sv
// Turns filtered accelerometer tilt into the spaceship sprite position,
// with a dead-zone, a speed ladder and clamping to the visible screen.
module ship_motion_ctrl
  import ship_pkg::*;
(
  input  logic                   slowclk,
  input  logic                   reset_n,
  input  logic                   sample_valid,
  input  logic signed [ACCW-1:0] accel_x,
  input  logic signed [ACCW-1:0] accel_y,
  input  logic                   freeze,
  output coord_t                 pos_x,
  output coord_t                 pos_y,
  output logic                   moving,
  output logic [3:0]             at_edge
);

  localparam coord_t X_MAX = coord_t'(H_RES - SPRITE_W);
  localparam coord_t Y_MAX = coord_t'(V_RES - SPRITE_H);

  logic signed [ACCW-1:0] w_avg_x;
  logic signed [ACCW-1:0] w_avg_y;
  logic [STEPW-1:0]       w_step_x;
  logic [STEPW-1:0]       w_step_y;
  coord_t                 w_next_x;
  coord_t                 w_next_y;
  logic [3:0]             w_edge;

  motion_state_t r_state;
  logic [1:0]    r_fill_cnt;
  logic          r_avg_ok;   // registered average now reflects a full window
  coord_t        r_pos_x;
  coord_t        r_pos_y;
  logic          r_moving;
  logic [3:0]    r_at_edge;

  axis_filter u_filt_x (
    .slowclk  (slowclk),
    .reset_n  (reset_n),
    .i_valid  (sample_valid),
    .i_sample (accel_x),
    .o_avg    (w_avg_x)
  );

  axis_filter u_filt_y (
    .slowclk  (slowclk),
    .reset_n  (reset_n),
    .i_valid  (sample_valid),
    .i_sample (accel_y),
    .o_avg    (w_avg_y)
  );

  // Step size and clamped candidate position for both axes.
  always_comb begin
    // NOTE: every output gets a value on every path through this block,
    // so no latch can be inferred.
    w_step_x = step_from_mag(sat_abs(w_avg_x), 16'(DEADZONE), 3'(STEP_MAX));
    w_step_y = step_from_mag(sat_abs(w_avg_y), 16'(DEADZONE), 3'(STEP_MAX));
    w_next_x = clamp_move(r_pos_x, w_avg_x, w_step_x, X_MAX);
    w_next_y = clamp_move(r_pos_y, w_avg_y, w_step_y, Y_MAX);
    w_edge   = {w_next_y == '0, w_next_y == Y_MAX,
                w_next_x == '0, w_next_x == X_MAX};
  end

  // Fill/run sequencing plus the registered position and status flags.
  always_ff @(posedge slowclk) begin
    if (!reset_n) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_avg_ok   <= 1'b0;
      r_pos_x    <= coord_t'(X_INIT);
      r_pos_y    <= coord_t'(Y_INIT);
      r_moving   <= 1'b0;
      r_at_edge  <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (sample_valid) begin
            r_fill_cnt <= r_fill_cnt + 2'd1;
            if (r_fill_cnt == 2'd3)
              r_state <= RUN;
          end
        end
        RUN: begin
          // The average lags the sum by one edge, so wait one RUN edge.
          r_avg_ok <= 1'b1;
          if (r_avg_ok && !freeze) begin
            r_pos_x   <= w_next_x;
            r_pos_y   <= w_next_y;
            r_at_edge <= w_edge;
            r_moving  <= (w_step_x != '0) || (w_step_y != '0);
          end else begin
            r_moving  <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign moving  = r_moving;
  assign at_edge = r_at_edge;

endmodule
